// File: rtl/seg7_pkg.sv
// Shared constants for the Nexys3 seven-segment scan driver: hex font, all-off
// patterns, slot phase type and the active-low anode decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low cathodes {g,f,e,d,c,b,a}; entry k is the glyph for hex digit k.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    function automatic logic [3:0] anode_drive(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            2'd3:    an = 4'b0111;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-cathode decoder using the shared hex font.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Font lookup
    always_comb begin
        seg_o = HEX_FONT[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver: latches a 16-bit value on a
// strobe and scans the digits with a per-slot blank interval and optional LZB.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000,
    parameter int LZB   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST_C  = CW'(DIV - 1);
    localparam logic [CW-1:0]  BLANK_C = CW'(BLANK);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    nib_s;
    logic [6:0]    font_s;
    logic          upper_zero_s;
    logic          suppress_s;
    phase_e        phase_s;

    // Slot counter and digit index advance
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == LAST_C) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + ONE_C;
            idx_d = idx_q;
        end
    end

    // Shadow capture; a held-high load simply reloads every cycle
    always_comb begin
        if (load) begin
            shadow_d = data;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Nibble select and leading-zero test for the digit being scanned
    always_comb begin
        nib_s        = shadow_q[3:0];
        upper_zero_s = 1'b0;
        case (idx_q)
            2'd0: begin
                nib_s        = shadow_q[3:0];
                upper_zero_s = 1'b0;
            end
            2'd1: begin
                nib_s        = shadow_q[7:4];
                upper_zero_s = (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib_s        = shadow_q[11:8];
                upper_zero_s = (shadow_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib_s        = shadow_q[15:12];
                upper_zero_s = (shadow_q[15:12] == 4'h0);
            end
            default: begin
                nib_s        = shadow_q[3:0];
                upper_zero_s = 1'b0;
            end
        endcase
    end

    hex_to_seg7 u_font (
        .nibble_i (nib_s),
        .seg_o    (font_s)
    );

    // Next pin state; digit 0 is never blanked so a zero value shows "0"
    always_comb begin
        an_d       = AN_OFF;
        seg_d      = font_s;
        dp_d       = 1'b1;
        suppress_s = (LZB != 0) && upper_zero_s;
        if (cnt_q < BLANK_C) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_DRIVE;
        end
        if ((phase_s == PH_DRIVE) && !suppress_s) begin
            an_d = anode_drive(idx_q);
            dp_d = ~dp_en[idx_q];
        end else begin
            an_d = AN_OFF;
            dp_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DIV=8, BLANK=2; one instance
// without and one with leading-zero blanking share the same stimulus.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_en;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    always #5 clock = ~clock;

    seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK), .LZB(0)) dut0 (
        .clock (clock), .reset (reset), .load (load), .data (data),
        .dp_en (dp_en), .an (an0), .seg (seg0), .dp (dp0)
    );

    seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK), .LZB(1)) dut1 (
        .clock (clock), .reset (reset), .load (load), .data (data),
        .dp_en (dp_en), .an (an1), .seg (seg1), .dp (dp1)
    );

    logic [6:0] font [16];

    typedef struct {
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       dp0;
        logic [3:0] an1;
        logic [6:0] seg1;
        logic       dp1;
    } exp_t;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpen;
        logic [3:0][6:0] segs;
        logic [3:0]      lit;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[6];
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_shadow;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_out(input bit lzb, output logic [3:0] a, output logic [6:0] s,
                             output logic d);
        logic [15:0] up;
        logic [3:0]  onehot;
        bit          off;
        up     = m_shadow >> (4 * m_idx);
        off    = (m_cnt < BLANK) || (lzb && (m_idx != 0) && (up == 16'h0000));
        onehot = 4'b0001 << m_idx;
        s      = font[up[3:0]];
        a      = off ? 4'hF : ~onehot;
        d      = off ? 1'b1 : ~dp_en[m_idx];
    endtask

    // One clock: predict, advance the model, then compare both instances.
    task automatic step();
        exp_t e;
        model_out(1'b0, e.an0, e.seg0, e.dp0);
        model_out(1'b1, e.an1, e.seg1, e.dp1);
        sb.push_back(e);
        if (load) m_shadow = data;
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt++;
        end
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("an_lzb0",  {28'd0, an0},  {28'd0, e.an0});
        chk("seg_lzb0", {25'd0, seg0}, {25'd0, e.seg0});
        chk("dp_lzb0",  {31'd0, dp0},  {31'd0, e.dp0});
        chk("an_lzb1",  {28'd0, an1},  {28'd0, e.an1});
        chk("seg_lzb1", {25'd0, seg1}, {25'd0, e.seg1});
        chk("dp_lzb1",  {31'd0, dp1},  {31'd0, e.dp1});
    endtask

    // Assert reset away from a clock edge and check the outputs drop at once.
    task automatic apply_reset();
        reset = 1'b0;
        #2;
        chk("rst_an0",  {28'd0, an0},  32'hF);
        chk("rst_seg0", {25'd0, seg0}, 32'h7F);
        chk("rst_dp0",  {31'd0, dp0},  32'h1);
        chk("rst_an1",  {28'd0, an1},  32'hF);
        chk("rst_seg1", {25'd0, seg1}, 32'h7F);
        chk("rst_dp1",  {31'd0, dp1},  32'h1);
        @(posedge clock);
        #1;
        chk("rst_hold_an1", {28'd0, an1}, 32'hF);
        m_cnt    = 0;
        m_idx    = 0;
        m_shadow = 16'h0000;
        sb.delete();
        reset = 1'b1;
        step();
        chk("post_rst_e1_an", {28'd0, an1}, 32'hF);
        step();
        chk("post_rst_e2_an", {28'd0, an1}, 32'hF);
        step();
        chk("post_rst_e3_an", {28'd0, an1}, 32'hE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drive0[4];
        int drive1[4];
        int dplow;
        int dpexp;
        int guard;

        font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // segs are {digit3, digit2, digit1, digit0}; lit marks digits shown with LZB on
        tbl[0] = '{16'h1234, 4'b0000, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        tbl[1] = '{16'h00A0, 4'b0000, {7'b1000000, 7'b1000000, 7'b0001000, 7'b1000000}, 4'b0011};
        tbl[2] = '{16'h0000, 4'b0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0001};
        tbl[3] = '{16'h89EF, 4'b0100, {7'b0000000, 7'b0010000, 7'b0000110, 7'b0001110}, 4'b1111};
        tbl[4] = '{16'h0C0D, 4'b0110, {7'b1000000, 7'b1000110, 7'b1000000, 7'b0100001}, 4'b0111};
        tbl[5] = '{16'h5B76, 4'b1001, {7'b0010010, 7'b0000011, 7'b1111000, 7'b0000010}, 4'b1111};

        reset = 1'b1;
        load  = 1'b0;
        data  = 16'h0000;
        dp_en = 4'b0000;
        #3;
        apply_reset();

        for (int i = 0; i < 6; i++) begin
            data  = tbl[i].data;
            dp_en = tbl[i].dpen;
            load  = 1'b1;
            step();
            load  = 1'b0;
            step();
            for (int k = 0; k < 4; k++) begin
                drive0[k] = 0;
                drive1[k] = 0;
            end
            dplow = 0;
            for (int c = 0; c < 4 * DIV; c++) begin
                step();
                for (int k = 0; k < 4; k++) begin
                    if (an0[k] == 1'b0) begin
                        drive0[k]++;
                        chk("tbl_seg_lzb0", {25'd0, seg0}, {25'd0, tbl[i].segs[k]});
                    end
                    if (an1[k] == 1'b0) begin
                        drive1[k]++;
                        chk("tbl_seg_lzb1", {25'd0, seg1}, {25'd0, tbl[i].segs[k]});
                    end
                end
                if (dp1 == 1'b0) dplow++;
            end
            dpexp = 0;
            for (int k = 0; k < 4; k++) begin
                chk("tbl_lit_lzb0", drive0[k], DIV - BLANK);
                chk("tbl_lit_lzb1", drive1[k], tbl[i].lit[k] ? DIV - BLANK : 0);
                if (tbl[i].dpen[k] && tbl[i].lit[k]) dpexp += DIV - BLANK;
            end
            chk("tbl_dp_cycles", dplow, dpexp);
        end

        // Reload twice inside digit 1's drive phase
        dp_en = 4'b0000;
        guard = 0;
        while (!(m_idx == 1 && m_cnt == 3) && guard < 64) begin
            step();
            guard++;
        end
        chk("align_digit1", (guard < 64) ? 32'd1 : 32'd0, 32'd1);
        data = 16'hFFFF;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("reload_F_seg", {25'd0, seg1}, {25'd0, 7'b0001110});
        chk("reload_F_an",  {28'd0, an1},  {28'd0, 4'b1101});
        data = 16'h8888;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("reload_8_seg", {25'd0, seg1}, {25'd0, 7'b0000000});
        chk("reload_8_an",  {28'd0, an1},  {28'd0, 4'b1101});

        // Load exactly on the slot-wrap cycle
        guard = 0;
        while (m_cnt != DIV - 1 && guard < 64) begin
            step();
            guard++;
        end
        chk("align_wrap", (guard < 64) ? 32'd1 : 32'd0, 32'd1);
        data = 16'h4321;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 0; c < DIV; c++) step();

        // Held-high load with changing data
        load = 1'b1;
        for (int c = 0; c < 6; c++) begin
            data = 16'h1111 * c;
            step();
        end
        load = 1'b0;
        for (int c = 0; c < 2 * DIV; c++) step();

        // Reset mid-slot, then resume scanning
        for (int c = 0; c < 5; c++) step();
        apply_reset();
        for (int c = 0; c < 4 * DIV; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
